// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared funct3 codes, FSM encoding and access sizing
// Purpose: common definitions for the load/store front-end.
// Contents: RV32I load/store funct3 constants, state_e, access_size().
package mem_access_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Byte count of an access; funct3[1:0] encodes the width for both
  // loads and stores. Width code 11 is never legal and yields 0.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - sign/zero extension of load data
// Purpose: select and extend the low bytes of the memory word for a load.
// Ports:
//   funct3_i  in  3   load funct3
//   data_i    in  32  raw word from dataMemory
//   data_o    out 32  extended load result
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      LB:      data_o = {{24{data_i[7]}}, data_i[7:0]};
      LH:      data_o = {{16{data_i[15]}}, data_i[15:0]};
      LBU:     data_o = {24'h000000, data_i[7:0]};
      LHU:     data_o = {16'h0000, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front-end to dataMemory
// Purpose: accept one memory op at a time, check funct3/alignment/range,
// issue a one-cycle request pulse to dataMemory and return a response.
// Ports:
//   clock, reset_n                      clock and async active-low reset
//   req_valid/req_ready                 op handshake from execute stage
//   req_is_store, req_funct3, req_addr, req_wdata, req_rd   op fields
//   loadUnitrequest, loadUnitreadAddr   read pulse and address
//   data_out                            read data from dataMemory
//   writeRequest, writeAddress, writeData, writeType   write pulse and fields
//   resp_valid/resp_ready               response handshake to writeback
//   resp_data, resp_rd, resp_fault      response fields
//   fault_count                         saturating count of faulted ops
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic             loadUnitrequest,
  output logic [31:0]      loadUnitreadAddr,
  input  logic [31:0]      data_out,
  output logic             writeRequest,
  output logic [31:0]      writeAddress,
  output logic [31:0]      writeData,
  output logic [2:0]       writeType,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [4:0]       resp_rd,
  output logic             resp_fault,
  output logic [CNT_W-1:0] fault_count
);

  state_e state_q, state_d;

  logic             req_ready_q, req_ready_d;
  logic             load_req_q, load_req_d;
  logic             write_req_q, write_req_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [2:0]       wr_type_q, wr_type_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [4:0]       resp_rd_q, resp_rd_d;
  logic             resp_fault_q, resp_fault_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_q, rd_d;

  logic        accept;
  logic        funct3_ok, align_ok, range_ok, op_fault;
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic [31:0] ext_data;

  assign accept = req_valid & req_ready_q;

  // Checks on the presented op; only consulted at the accepting edge.
  always_comb begin
    size = access_size(req_funct3);
    if (req_is_store) begin
      funct3_ok = (req_funct3 == SB) || (req_funct3 == SH) || (req_funct3 == SW);
    end else begin
      funct3_ok = (req_funct3 == LB) || (req_funct3 == LH) || (req_funct3 == LW) ||
                  (req_funct3 == LBU) || (req_funct3 == LHU);
    end
    case (size)
      3'd2:    align_ok = ~req_addr[0];
      3'd4:    align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    // 33-bit sum so an access straddling 2^32 cannot wrap into range.
    end_addr = {1'b0, req_addr} + {30'b0, size};
    range_ok = (end_addr <= 33'(MEM_BYTES));
    op_fault = ~(funct3_ok & align_ok & range_ok);
  end

  load_extend u_load_extend (
    .funct3_i (funct3_q),
    .data_i   (data_out),
    .data_o   (ext_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_fault ? RESP : ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = req_ready_q;
    load_req_d   = 1'b0;
    write_req_d  = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_type_d    = wr_type_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_fault_d = resp_fault_q;
    fault_cnt_d  = fault_cnt_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          is_store_d  = req_is_store;
          funct3_d    = req_funct3;
          rd_d        = req_rd;
          if (op_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_data_d  = 32'h0;
            resp_rd_d    = req_is_store ? 5'd0 : req_rd;
            if (~&fault_cnt_q) fault_cnt_d = fault_cnt_q + 1'b1;
          end else if (req_is_store) begin
            write_req_d = 1'b1;
            wr_addr_d   = req_addr;
            wr_data_d   = req_wdata;
            wr_type_d   = req_funct3;
          end else begin
            load_req_d = 1'b1;
            rd_addr_d  = req_addr;
          end
        end
      end
      HOLD: begin
        // data_out has settled a full cycle after the read pulse rose.
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_data_d  = is_store_q ? 32'h0 : ext_data;
        resp_rd_d    = is_store_q ? 5'd0 : rd_q;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q  <= 1'b1;
      load_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      rd_addr_q    <= 32'h0;
      wr_addr_q    <= 32'h0;
      wr_data_q    <= 32'h0;
      wr_type_q    <= 3'b000;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_rd_q    <= 5'd0;
      resp_fault_q <= 1'b0;
      fault_cnt_q  <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      rd_q         <= 5'd0;
    end else begin
      req_ready_q  <= req_ready_d;
      load_req_q   <= load_req_d;
      write_req_q  <= write_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_type_q    <= wr_type_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
      fault_cnt_q  <= fault_cnt_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign loadUnitrequest  = load_req_q;
  assign loadUnitreadAddr = rd_addr_q;
  assign writeRequest     = write_req_q;
  assign writeAddress     = wr_addr_q;
  assign writeData        = wr_data_q;
  assign writeType        = wr_type_q;
  assign resp_valid       = resp_valid_q;
  assign resp_data        = resp_data_q;
  assign resp_rd          = resp_rd_q;
  assign resp_fault       = resp_fault_q;
  assign fault_count      = fault_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_store = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic [4:0]    req_rd = 5'd0;
  logic          loadUnitrequest;
  logic [31:0]   loadUnitreadAddr;
  logic [31:0]   data_out = 32'h0;
  logic          writeRequest;
  logic [31:0]   writeAddress;
  logic [31:0]   writeData;
  logic [2:0]    writeType;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_data;
  logic [4:0]    resp_rd;
  logic          resp_fault;
  logic [CW-1:0] fault_count;

  int checks = 0;
  int errors = 0;
  int lat, n_ld, n_wr;

  logic [7:0] mem [0:1023];

  always #5 clock = ~clock;

  mem_access_unit #(.MEM_BYTES(1024), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .loadUnitrequest(loadUnitrequest), .loadUnitreadAddr(loadUnitreadAddr), .data_out(data_out),
    .writeRequest(writeRequest), .writeAddress(writeAddress), .writeData(writeData),
    .writeType(writeType), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_fault(resp_fault),
    .fault_count(fault_count)
  );

  function automatic logic [7:0] rb(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a[9:0]] : 8'h00;
  endfunction

  task automatic wb(input logic [31:0] a, input logic [7:0] d);
    if (a < 32'd1024) mem[a[9:0]] = d;
  endtask

  // Edge-triggered dataMemory model.
  always @(posedge writeRequest) begin
    #1;
    wb(writeAddress, writeData[7:0]);
    if (writeType != 3'b000) wb(writeAddress + 32'd1, writeData[15:8]);
    if (writeType == 3'b010) begin
      wb(writeAddress + 32'd2, writeData[23:16]);
      wb(writeAddress + 32'd3, writeData[31:24]);
    end
  end

  always @(posedge loadUnitrequest) begin
    #1;
    data_out = {rb(loadUnitreadAddr + 32'd3), rb(loadUnitreadAddr + 32'd2),
                rb(loadUnitreadAddr + 32'd1), rb(loadUnitreadAddr)};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one op, returns at the negedge where resp_valid is first seen.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        output int l, output int nl, output int nw);
    @(negedge clock);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    l = 0; nl = 0; nw = 0;
    while (l < 20) begin
      @(negedge clock);
      l++;
      if (loadUnitrequest) nl++;
      if (writeRequest) nw++;
      if (resp_valid) break;
    end
  endtask

  task automatic finish_resp(input string tag);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_resp_valid_drop"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_req_ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    run_op(1'b0, f3, addr, 32'h0, 5'd7, lat, n_ld, n_wr);
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_data"}, resp_data, exp);
    check({tag, "_fault"}, {31'b0, resp_fault}, 32'd0);
    finish_resp(tag);
  endtask

  task automatic fault_chk(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr);
    run_op(st, f3, addr, 32'h0, 5'd3, lat, n_ld, n_wr);
    check({tag, "_lat"}, lat, 32'd1);
    check({tag, "_fault"}, {31'b0, resp_fault}, 32'd1);
    check({tag, "_pulses"}, n_ld + n_wr, 32'd0);
    finish_resp(tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_ld_req", {31'b0, loadUnitrequest}, 32'd0);
    check("rst_wr_req", {31'b0, writeRequest}, 32'd0);
    check("rst_wr_addr", writeAddress, 32'd0);
    check("rst_fault_count", {28'b0, fault_count}, 32'd0);
    reset_n = 1'b1;

    // 1. SW then LW
    run_op(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 5'd9, lat, n_ld, n_wr);
    check("sw_lat", lat, 32'd3);
    check("sw_pulse_cycles", n_wr, 32'd1);
    check("sw_wtype", {29'b0, writeType}, 32'h2);
    check("sw_waddr", writeAddress, 32'd8);
    check("sw_wdata", writeData, 32'hDEADBEEF);
    check("sw_resp_data", resp_data, 32'h0);
    check("sw_resp_rd", {27'b0, resp_rd}, 32'd0);
    finish_resp("sw");
    run_op(1'b0, 3'b010, 32'd8, 32'h0, 5'd5, lat, n_ld, n_wr);
    check("lw_lat", lat, 32'd3);
    check("lw_pulse_cycles", n_ld, 32'd1);
    check("lw_raddr", loadUnitreadAddr, 32'd8);
    check("lw_data", resp_data, 32'hDEADBEEF);
    check("lw_rd", {27'b0, resp_rd}, 32'd5);
    check("lw_fault", {31'b0, resp_fault}, 32'd0);
    finish_resp("lw");

    // 2. extension
    load_chk("lb8", 3'b000, 32'd8, 32'hFFFFFFEF);
    load_chk("lbu8", 3'b100, 32'd8, 32'h000000EF);
    load_chk("lh10", 3'b001, 32'd10, 32'hFFFFDEAD);
    load_chk("lhu10", 3'b101, 32'd10, 32'h0000DEAD);

    // top-of-memory boundary
    run_op(1'b1, 3'b001, 32'd1022, 32'h12348001, 5'd0, lat, n_ld, n_wr);
    check("sh1022_fault", {31'b0, resp_fault}, 32'd0);
    check("sh1022_wtype", {29'b0, writeType}, 32'h1);
    finish_resp("sh1022");
    load_chk("lh1022", 3'b001, 32'd1022, 32'hFFFF8001);
    load_chk("lb1023", 3'b000, 32'd1023, 32'hFFFFFF80);

    // 3. faults
    fault_chk("lw6", 1'b0, 3'b010, 32'd6);
    check("fc_after_1", {28'b0, fault_count}, 32'd1);
    fault_chk("lw1022", 1'b0, 3'b010, 32'd1022);
    fault_chk("lw1024", 1'b0, 3'b010, 32'd1024);
    fault_chk("lb_wrap", 1'b0, 3'b000, 32'hFFFFFFFF);
    fault_chk("ld_f3_011", 1'b0, 3'b011, 32'd0);
    fault_chk("st_f3_100", 1'b1, 3'b100, 32'd0);
    check("fc_after_6", {28'b0, fault_count}, 32'd6);

    // 4. response backpressure
    resp_ready = 1'b0;
    run_op(1'b0, 3'b010, 32'd8, 32'h0, 5'd11, lat, n_ld, n_wr);
    check("bp_lat", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_data", resp_data, 32'hDEADBEEF);
      check("bp_rd", {27'b0, resp_rd}, 32'd11);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    finish_resp("bp");

    // 5. reset during ISSUE of a load
    @(negedge clock);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'd8;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rst_mid_pulse_up", {31'b0, loadUnitrequest}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_pulse_drop", {31'b0, loadUnitrequest}, 32'd0);
    check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_fc", {28'b0, fault_count}, 32'd0);
    load_chk("post_rst_lw", 3'b010, 32'd8, 32'hDEADBEEF);

    // 6. saturation (4-bit counter)
    for (int i = 0; i < 15; i++) begin
      run_op(1'b0, 3'b010, 32'd6, 32'h0, 5'd1, lat, n_ld, n_wr);
      finish_resp("sat_fill");
    end
    check("fc_saturated", {28'b0, fault_count}, 32'hF);
    fault_chk("sat_extra", 1'b0, 3'b010, 32'd6);
    check("fc_stays_saturated", {28'b0, fault_count}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
